averager_sequencer: RTL and testbench

- Run controller for the averager counter. Drives the counter's `clken`/`restart` so a software `start` yields exactly `avg_target` accumulated sweeps.
- Tracks the counter's flush/ready handshake, latches the reported `n_avg`, and flags completion.
- Supports single-shot and continuous modes. Sits between the AXI config/status registers and the averager counter.

---
 rtl/averager_pkg.sv | 14 +
 rtl/averager_sequencer_if.sv | 15 +
 rtl/averager_frame_tick.sv | 24 ++
 rtl/averager_sequencer.sv | 169 ++++++++++++++++
 tb/tb_averager_sequencer.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/averager_pkg.sv
// Shared widths, address layout and FSM state encodings for the averager sequencer.
package averager_pkg;
  localparam int FAST_COUNT_WIDTH_D = 13;
  localparam int SLOW_COUNT_WIDTH_D = 19;
  localparam int ADDR_LSB           = 2;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_ARM   = 3'd1;
  localparam state_t ST_FLUSH = 3'd2;
  localparam state_t ST_ACCUM = 3'd3;
  localparam state_t ST_CLOSE = 3'd4;
endpackage

// File: rtl/averager_sequencer_if.sv
// Sequencer <-> averager counter link: enable/restart out, flush status and sweep address back.
interface averager_sequencer_if import averager_pkg::*; #(
  parameter int FAST_COUNT_WIDTH = FAST_COUNT_WIDTH_D,
  parameter int SLOW_COUNT_WIDTH = SLOW_COUNT_WIDTH_D
);
  logic                        clken;
  logic                        restart;
  logic                        ready;
  logic                        wen;
  logic [SLOW_COUNT_WIDTH-1:0] n_avg;
  logic [FAST_COUNT_WIDTH+1:0] address;

  modport master (output clken, restart, input ready, wen, n_avg, address);
  modport slave  (input clken, restart, output ready, wen, n_avg, address);
endinterface

// File: rtl/averager_frame_tick.sv
// One-cycle strobe when the sweep-point index wraps to zero from a nonzero value.
module averager_frame_tick import averager_pkg::*; #(
  parameter int FAST_COUNT_WIDTH = FAST_COUNT_WIDTH_D
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [FAST_COUNT_WIDTH+1:0] i_address,
  output logic                        o_tick
);
  logic [FAST_COUNT_WIDTH-1:0] w_idx;
  logic [FAST_COUNT_WIDTH-1:0] r_idx_prev;
  logic                        w_unused_lsb;

  // Address is byte-addressed in 32-bit words; the two LSBs carry nothing.
  assign w_idx        = i_address[FAST_COUNT_WIDTH+1:ADDR_LSB];
  assign w_unused_lsb = ^i_address[ADDR_LSB-1:0];

  always_ff @(posedge clk) begin
    if (!resetn) r_idx_prev <= '0;
    else         r_idx_prev <= w_idx;
  end

  assign o_tick = (w_idx == '0) && (r_idx_prev != '0);
endmodule

// File: rtl/averager_sequencer.sv
// Run controller for the averager counter: drives clken/restart so one start yields avg_target sweeps.
// Optional `define ACQ_TRIG_EN adds a trig input and an ARM state that waits for a trig rising edge.
module averager_sequencer import averager_pkg::*; #(
  parameter int FAST_COUNT_WIDTH = FAST_COUNT_WIDTH_D,
  parameter int SLOW_COUNT_WIDTH = SLOW_COUNT_WIDTH_D
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        continuous,
  input  logic [SLOW_COUNT_WIDTH-1:0] avg_target,
`ifdef ACQ_TRIG_EN
  input  logic                        trig,
`endif
  averager_sequencer_if.master        cnt,
  output logic                        busy,
  output logic                        done,
  output logic [SLOW_COUNT_WIDTH-1:0] n_avg_out,
  output logic                        cfg_err
);
  localparam logic [SLOW_COUNT_WIDTH-1:0] ONE = SLOW_COUNT_WIDTH'(1);

  state_t                      r_state;
  logic [SLOW_COUNT_WIDTH-1:0] r_target;
  logic [SLOW_COUNT_WIDTH-1:0] r_frame_cnt;
  logic [SLOW_COUNT_WIDTH-1:0] r_n_avg_out;
  logic                        r_cont;
  logic                        r_clken;
  logic                        r_restart;
  logic                        r_done;
  logic                        r_cfg_err;
  logic                        r_seen_low;
  logic [SLOW_COUNT_WIDTH-1:0] w_frame_inc;
  logic                        w_tick;
  logic                        w_ready_rise;
  logic                        w_one;
  logic                        w_unused;

  averager_frame_tick #(.FAST_COUNT_WIDTH(FAST_COUNT_WIDTH)) u_frame_tick (
    .clk       (clk),
    .resetn    (resetn),
    .i_address (cnt.address),
    .o_tick    (w_tick)
  );

  assign w_frame_inc  = (&r_frame_cnt) ? r_frame_cnt : r_frame_cnt + ONE;
  assign w_ready_rise = r_seen_low & cnt.ready;
  assign w_one        = (r_target == ONE);
  assign w_unused     = cnt.wen;

`ifdef ACQ_TRIG_EN
  logic r_trig_d;
  logic w_trig_rise;

  always_ff @(posedge clk) begin
    if (!resetn) r_trig_d <= 1'b0;
    else         r_trig_d <= trig;
  end

  assign w_trig_rise = trig & ~r_trig_d;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_target    <= '0;
      r_frame_cnt <= '0;
      r_n_avg_out <= '0;
      r_cont      <= 1'b0;
      r_clken     <= 1'b0;
      r_restart   <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_seen_low  <= 1'b0;
    end else begin
      r_restart <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_clken <= 1'b0;
          if (start && !stop) begin
            if (avg_target == '0) begin
              r_cfg_err <= 1'b1;
            end else begin
              r_cfg_err  <= 1'b0;
              r_target   <= avg_target;
              r_cont     <= continuous;
              r_seen_low <= 1'b0;
`ifdef ACQ_TRIG_EN
              r_state    <= ST_ARM;
`else
              r_state    <= ST_FLUSH;
              r_clken    <= 1'b1;
              r_restart  <= 1'b1;
`endif
            end
          end
        end
`ifdef ACQ_TRIG_EN
        ST_ARM: begin
          if (w_trig_rise) begin
            r_state    <= ST_FLUSH;
            r_clken    <= 1'b1;
            r_restart  <= 1'b1;
            r_seen_low <= 1'b0;
          end
        end
`endif
        // The restart flushes whatever the counter had; wait for its full low/high cycle.
        ST_FLUSH: begin
          if (!cnt.ready) r_seen_low <= 1'b1;
          if (w_ready_rise) begin
            r_state     <= ST_ACCUM;
            r_frame_cnt <= '0;
            r_restart   <= w_one;
            r_seen_low  <= 1'b0;
          end
        end
        // Closing restart lands inside the final sweep so the counter reports exactly r_target.
        ST_ACCUM: begin
          if (r_restart) begin
            r_state    <= ST_CLOSE;
            r_seen_low <= 1'b0;
          end else if (w_tick) begin
            r_frame_cnt <= w_frame_inc;
            if (w_frame_inc == r_target - ONE) r_restart <= 1'b1;
          end
        end
        ST_CLOSE: begin
          if (!cnt.ready) r_seen_low <= 1'b1;
          if (w_ready_rise) begin
            r_done      <= 1'b1;
            r_n_avg_out <= cnt.n_avg;
            r_seen_low  <= 1'b0;
            r_frame_cnt <= '0;
            if (!r_cont) begin
              r_state <= ST_IDLE;
              r_clken <= 1'b0;
            end else begin
`ifdef ACQ_TRIG_EN
              r_state   <= ST_ARM;
              r_clken   <= 1'b0;
`else
              r_state   <= ST_ACCUM;
              r_restart <= w_one;
`endif
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      // Abort overrides any transition taken above.
      if (stop && (r_state != ST_IDLE)) begin
        r_state   <= ST_IDLE;
        r_clken   <= 1'b0;
        r_restart <= 1'b0;
        r_done    <= 1'b0;
      end
    end
  end

  assign cnt.clken   = r_clken;
  assign cnt.restart = r_restart;
  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;
  assign n_avg_out   = r_n_avg_out;
  assign cfg_err     = r_cfg_err;
endmodule

// File: tb/tb_averager_sequencer.sv
// Scoreboard bench for averager_sequencer against a behavioural averager counter (count_max=15).
module tb_averager_sequencer;
  import averager_pkg::*;

  localparam int FW   = FAST_COUNT_WIDTH_D;
  localparam int SW   = SLOW_COUNT_WIDTH_D;
  localparam int CMAX = 15;
`ifdef ACQ_TRIG_EN
  localparam bit CONT_CLKEN = 1'b0;
`else
  localparam bit CONT_CLKEN = 1'b1;
`endif

  typedef struct {
    int n;
    bit busy;
    bit clken;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn;
  logic          start;
  logic          stop;
  logic          continuous;
  logic [SW-1:0] avg_target;
  logic          busy;
  logic          done;
  logic [SW-1:0] n_avg_out;
  logic          cfg_err;
`ifdef ACQ_TRIG_EN
  logic          trig = 1'b0;
  bit            auto_trig = 1'b1;
  always @(negedge clk) if (auto_trig) trig = ~trig;
`endif

  averager_sequencer_if #(.FAST_COUNT_WIDTH(FW), .SLOW_COUNT_WIDTH(SW)) cif ();

  averager_sequencer #(.FAST_COUNT_WIDTH(FW), .SLOW_COUNT_WIDTH(SW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .stop       (stop),
    .continuous (continuous),
    .avg_target (avg_target),
`ifdef ACQ_TRIG_EN
    .trig       (trig),
`endif
    .cnt        (cif),
    .busy       (busy),
    .done       (done),
    .n_avg_out  (n_avg_out),
    .cfg_err    (cfg_err)
  );

  // Counter model: restart takes effect at the next wrap, which ends the sweep being
  // accumulated (counted in n_avg), then one flush sweep with ready low that is not counted.
  logic [FW-1:0] m_idx;
  logic          m_pend, m_flush, m_rdy;
  logic [SW-1:0] m_sweeps, m_navg;

  always @(posedge clk) begin
    if (!resetn) begin
      m_idx <= '0; m_pend <= 1'b0; m_flush <= 1'b0; m_rdy <= 1'b1;
      m_sweeps <= '0; m_navg <= '0;
    end else begin
      if (cif.restart) m_pend <= 1'b1;
      if (cif.clken) begin
        if (m_idx == FW'(CMAX)) begin
          m_idx <= '0;
          if (m_flush) begin
            m_flush <= 1'b0;
            m_rdy   <= 1'b1;
          end else if (m_pend || cif.restart) begin
            m_navg   <= m_sweeps + SW'(1);
            m_sweeps <= '0;
            m_flush  <= 1'b1;
            m_rdy    <= 1'b0;
            m_pend   <= 1'b0;
          end else begin
            m_sweeps <= m_sweeps + SW'(1);
          end
        end else begin
          m_idx <= m_idx + FW'(1);
        end
      end
    end
  end

  assign cif.address = {m_idx, 2'b00};
  assign cif.ready   = m_rdy;
  assign cif.wen     = m_flush;
  assign cif.n_avg   = m_navg;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   restart_cnt = 0;
  int   done_cnt = 0;
  logic prev_restart = 1'b0;
  exp_t exp_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: restart hygiene and scoreboard pop on every done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (cif.restart) begin
      restart_cnt++;
      check("restart_while_busy", busy, 1);
      check("restart_width", prev_restart, 0);
    end
    prev_restart = cif.restart;
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_done: got done with n_avg_out=%0d, expected no done", n_avg_out);
      end else begin
        e = exp_q.pop_front();
        check("done_n_avg_out", n_avg_out, e.n);
        check("done_busy", busy, e.busy);
        check("done_clken", cif.clken, e.clken);
      end
    end
  end

  task automatic pulse_start(input int tgt, input bit cont);
    avg_target = SW'(tgt);
    continuous = cont;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    avg_target = SW'(7);
    continuous = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    #1;
    check({name, "_timeout"}, busy, 0);
    check({name, "_pending"}, exp_q.size(), 0);
  endtask

  initial begin
    int base;
    int k;
    resetn = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0; avg_target = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("rst_clken", cif.clken, 0);
    check("rst_restart", cif.restart, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_n_avg_out", n_avg_out, 0);
    check("rst_cfg_err", cfg_err, 0);

    // Single-shot, 4 sweeps; a start while busy must be ignored.
    base = restart_cnt;
    exp_q.push_back('{4, 1'b0, 1'b0});
    pulse_start(4, 1'b0);
    check("single_busy", busy, 1);
    repeat (20) @(negedge clk);
    pulse_start(9, 1'b1);
    wait_idle("single", 1500);
    check("single_restarts", restart_cnt - base, 2);
    check("single_clken", cif.clken, 0);
    check("single_n_avg_out", n_avg_out, 4);

    // avg_target = 1: close on ACCUM entry.
    base = restart_cnt;
    exp_q.push_back('{1, 1'b0, 1'b0});
    pulse_start(1, 1'b0);
    wait_idle("one", 1500);
    check("one_restarts", restart_cnt - base, 2);
    check("one_n_avg_out", n_avg_out, 1);

    // Continuous, three completions of 3 sweeps, then stop.
    base = done_cnt;
    for (int i = 0; i < 3; i++) exp_q.push_back('{3, 1'b1, CONT_CLKEN});
    pulse_start(3, 1'b1);
    k = 0;
    while (done_cnt < base + 3 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    #1;
    check("cont_completions", done_cnt - base, 3);
    check("cont_busy", busy, 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_busy", busy, 0);
    check("stop_clken", cif.clken, 0);
    repeat (200) @(negedge clk);
    #1;
    check("stop_no_done", done_cnt - base, 3);
    check("stop_n_avg_out", n_avg_out, 3);

    // Zero target flags cfg_err; the next valid start clears it and runs.
    pulse_start(0, 1'b0);
    check("err_cfg_err", cfg_err, 1);
    check("err_busy", busy, 0);
    check("err_clken", cif.clken, 0);
    exp_q.push_back('{2, 1'b0, 1'b0});
    pulse_start(2, 1'b0);
    check("err_cleared", cfg_err, 0);
    wait_idle("err_run", 1500);
    check("err_n_avg_out", n_avg_out, 2);

    // start and stop together: stop wins.
    avg_target = SW'(4); start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("startstop_busy", busy, 0);
    check("startstop_clken", cif.clken, 0);

    // Reset while in CLOSE: everything back to reset values, no done.
    base = restart_cnt;
    pulse_start(2, 1'b0);
    k = 0;
    while (restart_cnt < base + 2 && k < 1500) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    #1;
    check("close_reached", restart_cnt - base, 2);
    resetn = 1'b0;
    @(negedge clk);
    check("midrst_clken", cif.clken, 0);
    check("midrst_restart", cif.restart, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_n_avg_out", n_avg_out, 0);
    resetn = 1'b1;
    repeat (40) @(negedge clk);
    check("midrst_idle", busy, 0);

`ifdef ACQ_TRIG_EN
    auto_trig = 1'b0;
    trig      = 1'b0;
    @(negedge clk);
    base = restart_cnt;
    pulse_start(5, 1'b0);
    repeat (100) @(negedge clk);
    #1;
    check("arm_clken", cif.clken, 0);
    check("arm_busy", busy, 1);
    check("arm_no_restart", restart_cnt - base, 0);
    exp_q.push_back('{5, 1'b0, 1'b0});
    trig = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("trig_restart", restart_cnt - base, 1);
    trig = 1'b0;
    wait_idle("trig_run", 2000);
    check("trig_n_avg_out", n_avg_out, 5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
